// File: rtl/frame_issue_ctrl.sv
// Frame issue controller: passes pixels to a classifier and stalls at frame
// boundaries while MAX_INFLIGHT frames await results. Results leave tagged in issue order.
`timescale 1ns/1ps
module frame_issue_ctrl #(
    parameter int PIX_BITS     = 8,
    parameter int IMG_DIM      = 30,
    parameter int MAX_INFLIGHT = 1,
    parameter int RES_BITS     = 4,
    parameter int TAG_BITS     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_BITS-1:0] s_pixel,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [PIX_BITS-1:0] m_pixel,
    output logic                m_valid,
    input  logic [RES_BITS-1:0] res_i,
    input  logic                res_valid_i,
    output logic [RES_BITS-1:0] r_digit,
    output logic [TAG_BITS-1:0] r_tag,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [4:0]          inflight,
    output logic [TAG_BITS-1:0] frame_idx,
    output logic                err_unexpected,
    output logic                err_overflow
);

    localparam int FRAME_PIX = IMG_DIM * IMG_DIM;
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int PTR_W     = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [4:0]       INFL_MAX = 5'(MAX_INFLIGHT);

    typedef enum logic {ISSUE = 1'b0, STALL = 1'b1} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    pix_cnt;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [TAG_BITS-1:0] tag_mem [MAX_INFLIGHT];
    logic                accept, push, pop;
    logic [4:0]          inflight_next;

    assign accept = s_valid && s_ready;
    assign push   = accept && (pix_cnt == CNT_LAST);
    assign pop    = res_valid_i && (inflight != 5'd0);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        inflight_next = inflight;
        case ({push, pop})
            2'b10:   inflight_next = inflight + 5'd1;
            2'b01:   inflight_next = inflight - 5'd1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ISSUE;
        else     state <= state_next;
    end

    // Stall entry can only follow a frame's last pixel, so it always lands on pixel count 0.
    always_comb begin
        state_next = state;
        case (state)
            ISSUE:   if (push && inflight_next == INFL_MAX) state_next = STALL;
            STALL:   if (inflight_next < INFL_MAX)          state_next = ISSUE;
            default: state_next = ISSUE;
        endcase
    end

    always_comb begin
        s_ready = (state == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt        <= '0;
            frame_idx      <= '0;
            inflight       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            m_pixel        <= '0;
            m_valid        <= 1'b0;
            r_valid        <= 1'b0;
            r_digit        <= '0;
            r_tag          <= '0;
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            m_valid  <= accept;
            inflight <= inflight_next;
            if (accept) begin
                m_pixel <= s_pixel;
                pix_cnt <= push ? '0 : pix_cnt + 1'b1;
            end
            if (push) begin
                frame_idx <= frame_idx + 1'b1;
                wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                // A held, unconsumed result wins; the newcomer is lost but its tag still retires.
                if (!r_valid || r_ready) begin
                    r_valid <= 1'b1;
                    r_digit <= res_i;
                    r_tag   <= tag_mem[rd_ptr];
                end else begin
                    err_overflow <= 1'b1;
                end
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            if (res_valid_i && inflight == 5'd0) err_unexpected <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; the pointers and inflight count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= frame_idx;
    end

endmodule

// File: doc/frame_issue_ctrl.md
FRAME_ISSUE_CTRL -- requirements
Module: frame_issue_ctrl

Interface
REQ-001 SHALL have parameters: PIX_BITS, default 8, pixel width; IMG_DIM, default 30, frame side (IMG_DIM*IMG_DIM pixels/frame); MAX_INFLIGHT, default 1, range 1..16, frames issued but unresolved; RES_BITS, default 4, classifier result width; TAG_BITS, default 16, frame tag width.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 s_pixel  in  PIX_BITS  upstream pixel, show-ahead FIFO data.
REQ-005 s_valid  in  1  upstream pixel available (FIFO not empty).
REQ-006 s_ready  out  1  combinational pop strobe to upstream; a pixel is accepted when s_valid && s_ready.
REQ-007 m_pixel  out  PIX_BITS  registered pixel to classifier.
REQ-008 m_valid  out  1  m_pixel valid; downstream never back-pressures.
REQ-009 res_i  in  RES_BITS  classifier result; res_valid_i  in  1  one-cycle result strobe.
REQ-010 r_digit  out  RES_BITS, r_tag  out  TAG_BITS, r_valid  out  1, r_ready  in  1: tagged result output, valid/ready handshake.
REQ-011 inflight  out  5  frames issued, result pending; frame_idx  out  TAG_BITS  tag of the frame currently being issued.
REQ-012 err_unexpected  out  1, err_overflow  out  1: sticky error flags.

Function
REQ-013 SHALL implement two states: ISSUE (pixels flow) and STALL (frame boundary, inflight == MAX_INFLIGHT).
REQ-014 s_ready SHALL be 1 in ISSUE; in STALL it SHALL be 0; stalling occurs only at pixel count 0, never mid-frame.
REQ-015 ISSUE->STALL when the last pixel of a frame is accepted and inflight after update equals MAX_INFLIGHT; STALL->ISSUE the cycle after inflight drops below MAX_INFLIGHT.
REQ-016 Accepted pixel SHALL appear on m_pixel with m_valid=1 exactly 1 cycle later; m_valid=0 otherwise.
REQ-017 Pixel counter SHALL count accepted pixels 0..IMG_DIM*IMG_DIM-1 and wrap to 0 on the last pixel.
REQ-018 On last-pixel acceptance: frame_idx pushed into an internal tag queue of depth MAX_INFLIGHT, inflight +1, frame_idx +1 modulo 2^TAG_BITS.
REQ-019 res_valid_i with inflight>0: pop tag queue, inflight -1, load r_digit=res_i, r_tag=popped tag, r_valid=1 next cycle.
REQ-020 Last-pixel acceptance and res_valid_i in the same cycle: inflight unchanged, push and pop both performed, FIFO order preserved.
REQ-021 res_valid_i with inflight==0: result dropped, no state change, err_unexpected set.
REQ-022 r_valid SHALL clear after r_valid && r_ready unless a new result loads the same cycle (then r_valid stays 1 with new data).
REQ-023 res_valid_i while r_valid=1 and r_ready=0: held result kept, new result dropped, tag still popped, inflight still decremented, err_overflow set.
REQ-024 Error flags SHALL clear only on reset.

Reset
REQ-025 Asserting rst at any time, including mid-frame, SHALL immediately force: state ISSUE, pixel counter 0, inflight 0, frame_idx 0, tag queue empty, m_valid 0, m_pixel 0, r_valid 0, r_digit 0, r_tag 0, both error flags 0.
REQ-026 After rst deassertion s_ready SHALL be 1 on the first clock; no partially issued frame is resumed.

Verification
REQ-027 Defaults, s_valid held 1, no results: 900 pixels pass with 1-cycle latency, then s_ready=0, inflight=1, frame_idx=1; res_valid_i res_i=7 -> r_digit=7, r_tag=0, r_valid=1, s_ready=1 next cycle.
REQ-028 MAX_INFLIGHT=4, results withheld: exactly 3600 pixels accepted, inflight=4, stall; 4 results 3,1,4,1 -> r_tag 0,1,2,3 in order with matching digits.
REQ-029 MAX_INFLIGHT=2, result strobe coinciding with a frame's last pixel: inflight stays 1, no stall, tags remain ordered.
REQ-030 res_valid_i after reset with no frame issued -> err_unexpected=1, r_valid=0, inflight=0.
REQ-031 r_ready=0, two results back to back -> first result held, err_overflow=1, inflight decremented twice.
REQ-032 rst asserted after 450 pixels of frame 0 -> all outputs zero; next 900 pixels form a frame tagged 0.
